// File: rtl/data_memory_lsu_pkg.sv
// Shared definitions for the data memory load/store unit: funct3 encodings and FSM states.
package data_memory_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

endpackage

// File: rtl/data_memory_lsu_lane_align.sv
// Combinational lane logic: store replication and byte enables, access-fault decode,
// and load lane extraction with sign/zero extension of the registered read word.
module data_memory_lsu_lane_align
    import data_memory_lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_fault,
    input  logic [2:0]  i_rsp_funct3,
    input  logic [1:0]  i_rsp_lane,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata
);

    logic        w_illegal;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wdata      = i_wdata;
        o_be         = 4'b0000;
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_be    = 4'b0001 << i_lane;
            end
            F3_H: begin
                o_wdata      = {2{i_wdata[15:0]}};
                o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
                w_misaligned = i_lane[0];
            end
            F3_W: begin
                o_be         = 4'b1111;
                w_misaligned = |i_lane;
            end
            // Unsigned variants exist only for loads.
            F3_BU: w_illegal = i_we;
            F3_HU: begin
                w_illegal    = i_we;
                w_misaligned = i_lane[0];
            end
            default: w_illegal = 1'b1;
        endcase
        o_fault = w_illegal | w_misaligned;
    end

    assign w_byte = i_rword[{i_rsp_lane, 3'b000} +: 8];
    assign w_half = i_rsp_lane[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_rdata = i_rword;
        case (i_rsp_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_BU:   o_rdata = {24'h0, w_byte};
            F3_HU:   o_rdata = {16'h0, w_half};
            default: o_rdata = i_rword;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory with req/rsp handshake, fixed 1-cycle latency,
// fault flagging, and a self zero-fill sequence after every reset.
module data_memory_lsu
    import data_memory_lsu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_init_done
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_init_cnt;
    logic [IDX_W-1:0]   w_init_cnt_next;

    logic [31:0]        r_mem [0:DEPTH_WORDS-1];
    logic [31:0]        r_rword;

    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic               r_rsp_ld;
    logic [2:0]         r_rsp_funct3;
    logic [1:0]         r_rsp_lane;

    logic [31:0]        w_off;
    logic               w_in_range;
    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_align_fault;
    logic               w_fault;
    logic               w_st_en;
    logic [31:0]        w_st_data;
    logic [3:0]         w_st_be;
    logic [31:0]        w_ld_data;

    logic [IDX_W-1:0]   w_wr_idx;
    logic [3:0]         w_wr_be;
    logic [31:0]        w_wr_data;

    assign w_off      = i_req_addr - BASE_ADDR;
    assign w_in_range = (i_req_addr >= BASE_ADDR) && (w_off < SPAN);
    assign w_idx      = w_off[IDX_W+1:2];
    assign w_accept   = i_req_valid && (r_state == ST_READY);
    assign w_fault    = !w_in_range || w_align_fault;
    assign w_st_en    = w_accept && i_req_we && !w_fault;

    data_memory_lsu_lane_align u_lane_align (
        .i_we         (i_req_we),
        .i_funct3     (i_req_funct3),
        .i_lane       (w_off[1:0]),
        .i_wdata      (i_req_wdata),
        .o_wdata      (w_st_data),
        .o_be         (w_st_be),
        .o_fault      (w_align_fault),
        .i_rsp_funct3 (r_rsp_funct3),
        .i_rsp_lane   (r_rsp_lane),
        .i_rword      (r_rword),
        .o_rdata      (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        if (r_state == ST_INIT) begin
            w_init_cnt_next = r_init_cnt + 1'b1;
            if (r_init_cnt == IDX_W'(DEPTH_WORDS - 1))
                w_state_next = ST_READY;
        end
    end

    // Single write port shared by the zero-fill sequence and stores.
    always_comb begin
        w_wr_idx  = w_idx;
        w_wr_be   = w_st_en ? w_st_be : 4'b0000;
        w_wr_data = w_st_data;
        if (r_state == ST_INIT) begin
            w_wr_idx  = r_init_cnt;
            w_wr_be   = 4'b1111;
            w_wr_data = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr_be[b])
                r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
        end
        r_rword <= r_mem[w_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_ld     <= 1'b0;
            r_rsp_funct3 <= 3'd0;
            r_rsp_lane   <= 2'd0;
        end else begin
            r_rsp_valid  <= w_accept;
            r_rsp_err    <= w_accept && w_fault;
            r_rsp_ld     <= w_accept && !i_req_we && !w_fault;
            r_rsp_funct3 <= i_req_funct3;
            r_rsp_lane   <= w_off[1:0];
        end
    end

    assign o_req_ready = (r_state == ST_READY);
    assign o_init_done = (r_state == ST_READY);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_ld ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: stimulus pushes expected responses from a
// byte-array reference model; a monitor pops and compares each DUT response.
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] m_mem [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_lsu #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_init_done  (init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_zero();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    endfunction

    // Memory semantics from first principles: size, alignment, legality, little-endian bytes.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          size;
        logic        illegal;
        logic [31:0] v;
        size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        err     = illegal || (addr >= 32'd256) || ((addr % size) != 0);
        rd      = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) m_mem[addr + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | (32'(m_mem[addr + i]) << (8 * i));
                if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endtask

    // Called at a negedge; drives one request and returns at the following negedge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        model(we, f3, addr, wd, e.rd, e.err);
        e.cyc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at the negedge where rst is released; holds a load request to prove INIT ignores it.
    task automatic wait_init(input string name);
        int n;
        n          = 0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk(name, n, 64);
        chk({name, "_done"}, {31'h0, init_done}, 1);
        model_zero();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (rsp_valid) begin
                $display("rsp cyc=%0d rdata=%h err=%0b", cyc, rsp_rdata, rsp_err);
                n_vec++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rdata=%h err=%0b expected no response", rsp_rdata, rsp_err);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || rsp_rdata !== e.rd || rsp_err !== e.err) begin
                        n_bad++;
                        $display("FAIL rsp: got cyc=%0d rdata=%h err=%0b expected cyc=%0d rdata=%h err=%0b",
                                 cyc, rsp_rdata, rsp_err, e.cyc, e.rd, e.err);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missing_rsp: got rsp_valid=0 expected rdata=%h err=%0b at cyc=%0d",
                         e.rd, e.err, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        logic [2:0]  f;
        exp_t        e;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        model_zero();
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", {31'h0, rsp_err}, 0);
        chk("rst_init_done", {31'h0, init_done}, 0);

        // Reset in the middle of INIT.
        rst = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midinit_ready", {31'h0, req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("init_cycles");

        do_req(0, 3'd2, 32'h0, 0);
        do_req(1, 3'd2, 32'h4, 32'hDEADBEEF);
        do_req(0, 3'd2, 32'h4, 0);
        do_req(0, 3'd0, 32'h7, 0);
        do_req(0, 3'd4, 32'h7, 0);
        do_req(0, 3'd5, 32'h4, 0);
        do_req(1, 3'd2, 32'h6, 32'h11111111);
        do_req(0, 3'd1, 32'h5, 0);
        do_req(0, 3'd2, 32'h4, 0);
        do_req(0, 3'd3, 32'h4, 0);
        do_req(0, 3'd2, 32'h100, 0);
        do_req(1, 3'd2, 32'h100, 32'h12345678);
        do_req(1, 3'd2, 32'h10, 32'hCAFEF00D);
        do_req(0, 3'd2, 32'h10, 0);
        idle(1);
        do_req(1, 3'd2, 32'h8, 32'hA5A5A5A5);
        do_req(1, 3'd0, 32'h9, 32'h0000005A);
        do_req(1, 3'd1, 32'hA, 32'h00001234);
        do_req(0, 3'd2, 32'h8, 0);
        idle(2);

        // Reset while a response is in flight: it must vanish immediately.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h8;
        @(posedge clk);
        #2;
        rst = 1'b1;
        req_valid = 1'b0;
        sbq.delete();
        #1;
        chk("rst_drop_valid", {31'h0, rsp_valid}, 0);
        chk("rst_drop_ready", {31'h0, req_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit_cycles");
        do_req(0, 3'd2, 32'h8, 0);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                case ($urandom_range(0, 9))
                    8:       a = 32'd256 + $urandom_range(0, 255);
                    9:       a = $urandom;
                    default: a = $urandom_range(0, 255);
                endcase
                f = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                                : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0 && f <= 3'd2) f = f | 3'd4;
                do_req(1'($urandom_range(0, 1)), f, a, $urandom);
            end
        end
        idle(3);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
